programmable_delay_line: RTL and testbench



---
 rtl/programmable_delay_line.sv | 98 +++++++++
 tb/tb_programmable_delay_line.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/programmable_delay_line.sv
// Programmable delay line: WIDTH-bit words pass through up to MAX_DEPTH
// register stages, and the output is taken from a tap chosen at run time.
// Each stage carries a valid bit. A fill counter reports how many enabled
// shifts have happened since the last clear, and rotate mode feeds the
// selected tap back into stage 0 so the first D stages form a loop.
module programmable_delay_line #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 16,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic               rotate_i,
  input  logic [DEPTH_W-1:0] depth_sel_i,
  input  logic [WIDTH-1:0]   si_i,
  input  logic               si_valid_i,
  output logic [WIDTH-1:0]   so_o,
  output logic               so_valid_o,
  output logic               primed_o,
  output logic [DEPTH_W-1:0] fill_cnt_o
);

  localparam int                 IDX_W = $clog2(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  logic [WIDTH-1:0]   stage_q [MAX_DEPTH];
  logic [WIDTH-1:0]   stage_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld_q;
  logic [MAX_DEPTH-1:0] vld_d;
  logic [DEPTH_W-1:0] fill_q;
  logic [DEPTH_W-1:0] fill_d;
  logic [DEPTH_W-1:0] effDepth;
  logic [IDX_W-1:0]   tapIdx;

  // Clamp the requested delay to 1..MAX_DEPTH and derive the tap stage index
  always_comb begin
    effDepth = depth_sel_i;
    if (depth_sel_i == '0) begin
      effDepth = DEPTH_W'(1);
    end else if (depth_sel_i > MAX_D) begin
      effDepth = MAX_D;
    end
    tapIdx = IDX_W'(effDepth - DEPTH_W'(1));
  end

  assign so_o       = stage_q[tapIdx];
  assign so_valid_o = vld_q[tapIdx];
  assign primed_o   = (fill_q >= effDepth);
  assign fill_cnt_o = fill_q;

  // Next state: flush clears everything, otherwise an enabled shift advances
  // every stage and loads stage 0 from either the input or the tap
  always_comb begin
    stage_d = stage_q;
    vld_d   = vld_q;
    fill_d  = fill_q;
    if (flush_i) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stage_d[i] = '0;
      end
      vld_d  = '0;
      fill_d = '0;
    end else if (en_i) begin
      for (int i = 1; i < MAX_DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
        vld_d[i]   = vld_q[i-1];
      end
      if (rotate_i) begin
        stage_d[0] = stage_q[tapIdx];
        vld_d[0]   = vld_q[tapIdx];
      end else begin
        stage_d[0] = si_i;
        vld_d[0]   = si_valid_i;
      end
      if (fill_q != MAX_D) begin
        fill_d = fill_q + DEPTH_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      vld_q  <= '0;
      fill_q <= '0;
    end else begin
      stage_q <= stage_d;
      vld_q   <= vld_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_programmable_delay_line.sv
// Self-checking bench for programmable_delay_line. A history-queue model of
// the delay line is checked against the DUT every cycle, and directed
// scenarios pin specific hand-computed values.
module tb_programmable_delay_line;

  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 16;
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

  logic               clk;
  logic               rstN;
  logic               en;
  logic               flush;
  logic               rotate;
  logic [DEPTH_W-1:0] depthSel;
  logic [WIDTH-1:0]   si;
  logic               siValid;
  logic [WIDTH-1:0]   so;
  logic               soValid;
  logic               primed;
  logic [DEPTH_W-1:0] fillCnt;

  int checkCount = 0;
  int failCount  = 0;

  // Model state: word/valid that entered stage 0 k+1 enabled shifts ago sits at index k
  logic [WIDTH-1:0] histData[$];
  logic             histVld[$];
  int               modelFill = 0;
  bit               modelLive = 0;

  programmable_delay_line #(
    .WIDTH(WIDTH),
    .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rstN),
    .en_i(en),
    .flush_i(flush),
    .rotate_i(rotate),
    .depth_sel_i(depthSel),
    .si_i(si),
    .si_valid_i(siValid),
    .so_o(so),
    .so_valid_o(soValid),
    .primed_o(primed),
    .fill_cnt_o(fillCnt)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int effD(input logic [DEPTH_W-1:0] sel);
    if (sel == 0) return 1;
    if (int'(sel) > MAX_DEPTH) return MAX_DEPTH;
    return int'(sel);
  endfunction

  function automatic void clearModel();
    histData.delete();
    histVld.delete();
    for (int i = 0; i < MAX_DEPTH; i++) begin
      histData.push_back('0);
      histVld.push_back(1'b0);
    end
    modelFill = 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, then return just after the rising edge
  task automatic applyStimulus(input logic r, input logic e, input logic f, input logic rot,
                               input logic [DEPTH_W-1:0] d, input logic [WIDTH-1:0] data,
                               input logic dv);
    @(negedge clk);
    #1;
    rstN     = r;
    en       = e;
    flush    = f;
    rotate   = rot;
    depthSel = d;
    si       = data;
    siValid  = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic shiftIn(input logic [DEPTH_W-1:0] d, input logic [WIDTH-1:0] data);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, d, data, 1'b1);
  endtask

  // Model update at each rising edge: reset > flush > enabled shift
  always @(posedge clk) begin
    if (rstN === 1'b0) begin
      clearModel();
      modelLive = 1'b1;
    end else if (modelLive) begin
      if (flush) begin
        clearModel();
      end else if (en) begin
        logic [WIDTH-1:0] newData;
        logic             newVld;
        int               d;
        d = effD(depthSel);
        newData = rotate ? histData[d-1] : si;
        newVld  = rotate ? histVld[d-1]  : siValid;
        histData.push_front(newData);
        histVld.push_front(newVld);
        void'(histData.pop_back());
        void'(histVld.pop_back());
        if (modelFill < MAX_DEPTH) modelFill++;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge once reset has been seen
  always @(negedge clk) begin
    if (modelLive) begin
      int d;
      d = effD(depthSel);
      checkOutput("model_so", 32'(so), 32'(histData[d-1]));
      checkOutput("model_so_valid", 32'(soValid), 32'(histVld[d-1]));
      checkOutput("model_primed", 32'(primed), 32'(modelFill >= d));
      checkOutput("model_fill_cnt", 32'(fillCnt), 32'(modelFill));
    end
  end

  initial begin
    logic [WIDTH-1:0] rotExp [6];
    rotExp = '{8'h0B, 8'h0C, 8'h0A, 8'h0B, 8'h0C, 8'h0A};

    rstN = 1'b0; en = 1'b0; flush = 1'b0; rotate = 1'b0;
    depthSel = '0; si = '0; siValid = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 8'h00, 1'b0);
    checkOutput("reset_so", 32'(so), 32'h0);
    checkOutput("reset_so_valid", 32'(soValid), 32'h0);
    checkOutput("reset_primed", 32'(primed), 32'h0);
    checkOutput("reset_fill", 32'(fillCnt), 32'h0);

    // D=4 continuous stream
    for (int i = 1; i <= 6; i++) begin
      shiftIn(5'd4, 8'(i));
      if (i == 3) begin
        checkOutput("d4_primed_before", 32'(primed), 32'h0);
        checkOutput("d4_valid_before", 32'(soValid), 32'h0);
      end
      if (i == 4) begin
        checkOutput("d4_so", 32'(so), 32'h01);
        checkOutput("d4_so_valid", 32'(soValid), 32'h1);
        checkOutput("d4_primed", 32'(primed), 32'h1);
        checkOutput("d4_fill", 32'(fillCnt), 32'h4);
      end
    end

    // D=4 with enable toggling: only enabled edges count
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 8'h00, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      logic on;
      on = (e % 2) == 1;
      applyStimulus(1'b1, on, 1'b0, 1'b0, 5'd4, on ? 8'((e + 1) / 2) : 8'hEE, 1'b1);
      if (e == 6) checkOutput("toggle_so_early", 32'(so), 32'h0);
      if (e == 7) checkOutput("toggle_so", 32'(so), 32'h01);
      if (e == 8) checkOutput("toggle_hold", 32'(so), 32'h01);
    end

    // depth_sel=0 behaves as D=1
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    shiftIn(5'd0, 8'h33);
    checkOutput("d0_so", 32'(so), 32'h33);
    checkOutput("d0_primed", 32'(primed), 32'h1);

    // depth_sel above MAX_DEPTH clamps to MAX_DEPTH; fill saturates
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd19, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      shiftIn(5'd19, 8'(8'h40 + i));
      if (i == 14) checkOutput("d19_valid_before", 32'(soValid), 32'h0);
      if (i == 15) checkOutput("d19_so", 32'(so), 32'h40);
    end
    checkOutput("d19_so_late", 32'(so), 32'h44);
    checkOutput("fill_saturate", 32'(fillCnt), 32'd16);

    // Rotate with D=3
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 8'h00, 1'b0);
    shiftIn(5'd3, 8'h0A);
    shiftIn(5'd3, 8'h0B);
    shiftIn(5'd3, 8'h0C);
    checkOutput("rot_start", 32'(so), 32'h0A);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 8'hFF, 1'b1);
      checkOutput("rot_so", 32'(so), 32'(rotExp[k]));
      checkOutput("rot_valid", 32'(soValid), 32'h1);
    end

    // Flush with simultaneous enable drops that cycle's input
    shiftIn(5'd4, 8'h11);
    shiftIn(5'd4, 8'h12);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 8'h55, 1'b1);
    checkOutput("flush_so", 32'(so), 32'h0);
    checkOutput("flush_valid", 32'(soValid), 32'h0);
    checkOutput("flush_fill", 32'(fillCnt), 32'h0);
    checkOutput("flush_primed", 32'(primed), 32'h0);
    for (int i = 0; i < 4; i++) shiftIn(5'd4, 8'(8'h60 + i));
    checkOutput("flush_after", 32'(so), 32'h60);

    // Mid-stream reset while enabled, then depth change 4 -> 8
    shiftIn(5'd4, 8'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 8'h77, 1'b1);
    checkOutput("rst_so", 32'(so), 32'h0);
    checkOutput("rst_valid", 32'(soValid), 32'h0);
    checkOutput("rst_fill", 32'(fillCnt), 32'h0);
    for (int i = 1; i <= 5; i++) shiftIn(5'd4, 8'(8'h20 + i));
    checkOutput("d4_five_so", 32'(so), 32'h22);
    checkOutput("d4_five_primed", 32'(primed), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 8'h00, 1'b0);
    checkOutput("d8_primed", 32'(primed), 32'h0);
    checkOutput("d8_valid", 32'(soValid), 32'h0);
    checkOutput("d8_fill", 32'(fillCnt), 32'h5);
    for (int i = 6; i <= 8; i++) shiftIn(5'd8, 8'(8'h20 + i));
    checkOutput("d8_so", 32'(so), 32'h21);
    checkOutput("d8_valid_after", 32'(soValid), 32'h1);
    checkOutput("d8_primed_after", 32'(primed), 32'h1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
